// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with the architectural NZVC flag register and B.cond evaluation.
// Optional macro FLAG_BYPASS_EN: forward the flags of an in-flight flag-setter into cond_pass.
module ex_mem_pipe #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32,
  parameter int REG_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [INSTR_W-1:0] ex_opcode,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [DATA_W-1:0]  ex_store_data,
  input  logic [REG_W-1:0]   ex_dest_reg,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic               ex_memwrite,
  input  logic               ex_memtoreg,
  input  logic               ex_setflags,
  input  logic               negative,
  input  logic               zero,
  input  logic               overflow,
  input  logic               carryout,
  input  logic               mem_ready,
  input  logic               flush,
  input  logic [3:0]         cond_code,
  output logic               ex_stall,
  output logic               mem_valid,
  output logic [INSTR_W-1:0] mem_opcode,
  output logic [DATA_W-1:0]  mem_alu_result,
  output logic [DATA_W-1:0]  mem_store_data,
  output logic [REG_W-1:0]   mem_dest_reg,
  output logic               mem_regwrite,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               mem_memtoreg,
  output logic               flag_n,
  output logic               flag_z,
  output logic               flag_v,
  output logic               flag_c,
  output logic               cond_pass,
  output logic               flag_hazard
);

  function automatic logic eval_cond(input logic [3:0] cc, input logic n, input logic z,
                                     input logic v, input logic c);
    logic r;
    case (cc)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = c;
      4'h3:    r = ~c;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = c & ~z;
      4'h9:    r = ~(c & ~z);
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = ~(~z & (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [DATA_W-1:0]  store_q, store_d;
  logic [REG_W-1:0]   dest_q, dest_d;
  logic               regwrite_q, regwrite_d;
  logic               memread_q, memread_d;
  logic               memwrite_q, memwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic [3:0]         nzvc_q, nzvc_d;
  logic               capture_s;
  logic               accept_s;
  logic               setflags_s;

  assign ex_stall   = valid_q & ~mem_ready;
  assign capture_s  = ~ex_stall;
  assign accept_s   = ex_valid & ~flush;
  assign setflags_s = accept_s & ex_setflags;

  // Next-state for the single pipeline entry and the flag register.
  always_comb begin
    valid_d    = valid_q;
    opcode_d   = opcode_q;
    result_d   = result_q;
    store_d    = store_q;
    dest_d     = dest_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    nzvc_d     = nzvc_q;
    if (capture_s) begin
      valid_d    = accept_s;
      opcode_d   = ex_opcode;
      result_d   = ex_result;
      store_d    = ex_store_data;
      dest_d     = ex_dest_reg;
      regwrite_d = ex_regwrite & accept_s;
      memread_d  = ex_memread & accept_s;
      memwrite_d = ex_memwrite & accept_s;
      memtoreg_d = ex_memtoreg & accept_s;
      if (setflags_s) begin
        nzvc_d = {negative, zero, overflow, carryout};
      end else begin
        nzvc_d = nzvc_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry and flag registers; reset empties the pipeline and clears the flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      result_q   <= '0;
      store_q    <= '0;
      dest_q     <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      nzvc_q     <= 4'b0000;
    end else begin
      valid_q    <= valid_d;
      opcode_q   <= opcode_d;
      result_q   <= result_d;
      store_q    <= store_d;
      dest_q     <= dest_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      nzvc_q     <= nzvc_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_opcode     = opcode_q;
  assign mem_alu_result = result_q;
  assign mem_store_data = store_q;
  assign mem_dest_reg   = dest_q;
  assign mem_regwrite   = regwrite_q;
  assign mem_memread    = memread_q;
  assign mem_memwrite   = memwrite_q;
  assign mem_memtoreg   = memtoreg_q;
  assign flag_n         = nzvc_q[3];
  assign flag_z         = nzvc_q[2];
  assign flag_v         = nzvc_q[1];
  assign flag_c         = nzvc_q[0];

`ifdef FLAG_BYPASS_EN
  logic [3:0] cond_flags_s;

  // Forward the in-flight flag-setter's flags so B.cond need not wait for the register.
  always_comb begin
    cond_flags_s = nzvc_q;
    if (setflags_s) begin
      cond_flags_s = {negative, zero, overflow, carryout};
    end else begin
      cond_flags_s = nzvc_q;
    end
  end

  assign cond_pass   = eval_cond(cond_code, cond_flags_s[3], cond_flags_s[2],
                                 cond_flags_s[1], cond_flags_s[0]);
  assign flag_hazard = 1'b0;
`else
  assign cond_pass   = eval_cond(cond_code, nzvc_q[3], nzvc_q[2], nzvc_q[1], nzvc_q[0]);
  assign flag_hazard = setflags_s;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed self-checking bench for ex_mem_pipe; expected values are hand-computed.
module tb_ex_mem_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_opcode;
  logic [63:0] ex_result;
  logic [63:0] ex_store_data;
  logic [4:0]  ex_dest_reg;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_setflags;
  logic        negative, zero, overflow, carryout;
  logic        mem_ready, flush;
  logic [3:0]  cond_code;
  logic        ex_stall, mem_valid;
  logic [31:0] mem_opcode;
  logic [63:0] mem_alu_result, mem_store_data;
  logic [4:0]  mem_dest_reg;
  logic        mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
  logic        flag_n, flag_z, flag_v, flag_c, cond_pass, flag_hazard;

  int checks = 0;
  int errors = 0;

  ex_mem_pipe dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_setflags(ex_setflags), .negative(negative),
    .zero(zero), .overflow(overflow), .carryout(carryout), .mem_ready(mem_ready),
    .flush(flush), .cond_code(cond_code), .ex_stall(ex_stall), .mem_valid(mem_valid),
    .mem_opcode(mem_opcode), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_dest_reg(mem_dest_reg),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .flag_c(flag_c), .cond_pass(cond_pass), .flag_hazard(flag_hazard)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_opcode = 32'h0; ex_result = 64'h0; ex_store_data = 64'h0;
    ex_dest_reg = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_memtoreg = 1'b0; ex_setflags = 1'b0; negative = 1'b0; zero = 1'b0;
    overflow = 1'b0; carryout = 1'b0; flush = 1'b0; cond_code = 4'h0;
  endtask

  task automatic set_flags(input logic n, input logic z, input logic v, input logic c);
    idle_inputs();
    ex_valid = 1'b1; ex_setflags = 1'b1; mem_ready = 1'b1;
    negative = n; zero = z; overflow = v; carryout = c;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    mem_ready = 1'b1;
    reset = 1'b0;
    #12;
    check_eq("rst_valid", {63'd0, mem_valid}, 64'd0);
    check_eq("rst_flags", {60'd0, flag_n, flag_z, flag_v, flag_c}, 64'd0);
    check_eq("rst_stall", {63'd0, ex_stall}, 64'd0);
    reset = 1'b1;

    // Basic capture with 1-cycle latency
    ex_valid = 1'b1; ex_opcode = 32'hCB000000; ex_result = 64'h10; ex_dest_reg = 5'd3;
    ex_regwrite = 1'b1;
    tick();
    check_eq("cap_valid", {63'd0, mem_valid}, 64'd1);
    check_eq("cap_result", mem_alu_result, 64'h10);
    check_eq("cap_dest", {59'd0, mem_dest_reg}, 64'd3);
    check_eq("cap_regwr", {63'd0, mem_regwrite}, 64'd1);
    check_eq("cap_opcode", {32'd0, mem_opcode}, 64'hCB000000);
    check_eq("cap_memrd", {63'd0, mem_memread}, 64'd0);

    // Back-pressure: three stalled cycles, a flag-setter waits in EX
    mem_ready = 1'b0; ex_result = 64'h20; ex_dest_reg = 5'd5;
    ex_setflags = 1'b1; negative = 1'b1;
    #1;
    check_eq("stall_on", {63'd0, ex_stall}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_result = 64'h20 + 64'(i) + 64'd1;
      check_eq("stall_hold", mem_alu_result, 64'h10);
      check_eq("stall_dest", {59'd0, mem_dest_reg}, 64'd3);
    end
    check_eq("stall_flagn", {63'd0, flag_n}, 64'd0);
    mem_ready = 1'b1;
    #1;
    check_eq("stall_off", {63'd0, ex_stall}, 64'd0);
    tick();
    check_eq("release_res", mem_alu_result, 64'h23);
    check_eq("release_dst", {59'd0, mem_dest_reg}, 64'd5);
    check_eq("release_fln", {63'd0, flag_n}, 64'd1);

    // Flush kills the EX instruction and its flag update
    idle_inputs();
    ex_valid = 1'b1; ex_setflags = 1'b1; zero = 1'b1; negative = 1'b0;
    ex_regwrite = 1'b1; flush = 1'b1;
    tick();
    check_eq("flush_valid", {63'd0, mem_valid}, 64'd0);
    check_eq("flush_regwr", {63'd0, mem_regwrite}, 64'd0);
    check_eq("flush_flags", {60'd0, flag_n, flag_z, flag_v, flag_c}, 64'h8);

    // Bubble in MEM never stalls
    idle_inputs();
    mem_ready = 1'b0;
    #1;
    check_eq("bubble_stall", {63'd0, ex_stall}, 64'd0);

    // Store path
    ex_valid = 1'b1; ex_result = 64'h100; ex_store_data = 64'hDEADBEEF_CAFEF00D;
    ex_memwrite = 1'b1; ex_memtoreg = 1'b1;
    tick();
    check_eq("st_data", mem_store_data, 64'hDEADBEEF_CAFEF00D);
    check_eq("st_ctrl", {62'd0, mem_memwrite, mem_memtoreg}, 64'd3);
    mem_ready = 1'b1;
    idle_inputs();
    tick();

    // SUBS sets Z and C; evaluate several conditions
    set_flags(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("subs_flags", {60'd0, flag_n, flag_z, flag_v, flag_c}, 64'h5);
    cond_code = 4'h0; #1; check_eq("cond_eq", {63'd0, cond_pass}, 64'd1);
    cond_code = 4'h1; #1; check_eq("cond_ne", {63'd0, cond_pass}, 64'd0);
    cond_code = 4'h8; #1; check_eq("cond_hi", {63'd0, cond_pass}, 64'd0);
    cond_code = 4'h9; #1; check_eq("cond_ls", {63'd0, cond_pass}, 64'd1);
    cond_code = 4'hB; #1; check_eq("cond_lt", {63'd0, cond_pass}, 64'd0);
    cond_code = 4'hA; #1; check_eq("cond_ge", {63'd0, cond_pass}, 64'd1);
    cond_code = 4'hF; #1; check_eq("cond_al", {63'd0, cond_pass}, 64'd1);

    // N set, V clear: LT/GT/LE/MI
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    cond_code = 4'hB; #1; check_eq("cond_lt2", {63'd0, cond_pass}, 64'd1);
    cond_code = 4'hC; #1; check_eq("cond_gt2", {63'd0, cond_pass}, 64'd0);
    cond_code = 4'hD; #1; check_eq("cond_le2", {63'd0, cond_pass}, 64'd1);
    cond_code = 4'h4; #1; check_eq("cond_mi2", {63'd0, cond_pass}, 64'd1);
    cond_code = 4'h6; #1; check_eq("cond_vs2", {63'd0, cond_pass}, 64'd0);

    // Flag hazard / bypass with an in-flight flag-setter
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("clr_flags", {60'd0, flag_n, flag_z, flag_v, flag_c}, 64'h0);
    ex_valid = 1'b1; ex_setflags = 1'b1; zero = 1'b1; cond_code = 4'h0;
    #1;
`ifdef FLAG_BYPASS_EN
    check_eq("byp_pass", {63'd0, cond_pass}, 64'd1);
    check_eq("byp_hazard", {63'd0, flag_hazard}, 64'd0);
`else
    check_eq("haz_pass", {63'd0, cond_pass}, 64'd0);
    check_eq("haz_hazard", {63'd0, flag_hazard}, 64'd1);
`endif
    flush = 1'b1;
    #1;
    check_eq("haz_flushed", {63'd0, flag_hazard}, 64'd0);
    idle_inputs();

    // Asynchronous reset while an entry is held under stall
    ex_valid = 1'b1; ex_result = 64'h55; ex_regwrite = 1'b1; ex_setflags = 1'b1;
    carryout = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("pre_rst_stall", {63'd0, ex_stall}, 64'd1);
    reset = 1'b0;
    #1;
    check_eq("arst_valid", {63'd0, mem_valid}, 64'd0);
    check_eq("arst_result", mem_alu_result, 64'd0);
    check_eq("arst_regwr", {63'd0, mem_regwrite}, 64'd0);
    check_eq("arst_flags", {60'd0, flag_n, flag_z, flag_v, flag_c}, 64'd0);
    check_eq("arst_stall", {63'd0, ex_stall}, 64'd0);
    idle_inputs();
    reset = 1'b1;
    tick();
    check_eq("restart_valid", {63'd0, mem_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
